// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and display patterns for the ALU
// command sequencer.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_PASS  = 4'd0,
        OP_LAMP  = 4'd1,
        OP_CYCLE = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_MUL   = 4'd5,
        OP_DIV   = 4'd6,
        OP_MOD   = 4'd7,
        OP_AND   = 4'd8,
        OP_OR    = 4'd9,
        OP_XOR   = 4'd10,
        OP_NOT   = 4'd11,
        OP_SHL   = 4'd12,
        OP_SHR   = 4'd13,
        OP_NAND  = 4'd14,
        OP_XNOR  = 4'd15
    } alu_opcode_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_SHOW   = 3'd3,
        S_LAMP   = 3'd4,
        S_CYCLE  = 3'd5
    } seq_state_t;

    localparam logic [15:0] ERR_PATTERN  = 16'hEEEE;
    localparam logic [15:0] LAMP_PATTERN = 16'h8888;

    // Same hex digit on all four display positions.
    function automatic logic [15:0] replicate_digit(input logic [3:0] digit);
        return {4{digit}};
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV enabled
// cycles. clear restarts the count and suppresses the tick in that cycle.
module tick_prescaler #(
    parameter int TICK_DIV = 100000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && !clear && (cnt == LAST);

    // Count enabled cycles, wrapping on the tick.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command sequencer between the board switches/GO button and the ALU.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | after reset, nothing shown, waiting for GO
// S_LAUNCH | one cycle, alu_start high with latched op/operands
// S_WAIT   | waiting for alu_done, bounded by ALU_TIMEOUT cycles
// S_SHOW   | holding a result, error pattern or pass-through value
// S_LAMP   | all segments and LEDs forced on
// S_CYCLE  | stepping one hex digit and the LED counter every tick
module alu_op_sequencer #(
    parameter int TICK_DIV    = 100000000,
    parameter int ALU_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] switches,
    input  logic        go,
    output logic        alu_start,
    output logic [3:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    input  logic        alu_err,
    output logic [15:0] disp_value,
    output logic [15:0] led,
    output logic        lamp_test,
    output logic        busy,
    output logic        err
);

    import alu_seq_pkg::*;

    localparam int WCW = (ALU_TIMEOUT > 1) ? $clog2(ALU_TIMEOUT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(ALU_TIMEOUT - 1);

    seq_state_t   state;
    alu_opcode_t  sw_op;
    logic [7:0]   sw_a;
    logic [7:0]   sw_b;
    logic         accept;
    logic         tick;
    logic [WCW-1:0] wait_cnt;
    logic [3:0]   digit;
    logic [3:0]   digit_next;
    logic         unused_sw_hi;

    assign sw_op        = alu_opcode_t'(switches[19:16]);
    assign sw_a         = switches[15:8];
    assign sw_b         = switches[7:0];
    assign unused_sw_hi = ^switches[23:20];

    assign busy       = (state == S_LAUNCH) || (state == S_WAIT);
    assign accept     = go && !busy;
    assign digit_next = digit + 4'd1;

    // Prescaler only runs in cycle mode and restarts on every accepted GO.
    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (accept || (state != S_CYCLE)),
        .en    (state == S_CYCLE),
        .tick  (tick)
    );

    // Main sequencer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            alu_start  <= 1'b0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            disp_value <= '0;
            led        <= '0;
            lamp_test  <= 1'b0;
            err        <= 1'b0;
            wait_cnt   <= '0;
            digit      <= '0;
        end else begin
            alu_start <= 1'b0;
            if (accept) begin
                alu_op    <= sw_op;
                alu_a     <= sw_a;
                alu_b     <= sw_b;
                err       <= 1'b0;
                lamp_test <= 1'b0;
                wait_cnt  <= '0;
                digit     <= '0;
                case (sw_op)
                    OP_PASS: begin
                        state      <= S_SHOW;
                        disp_value <= {sw_a, sw_b};
                        led        <= {sw_op, 12'b0};
                    end
                    OP_LAMP: begin
                        state      <= S_LAMP;
                        lamp_test  <= 1'b1;
                        led        <= 16'hFFFF;
                        disp_value <= LAMP_PATTERN;
                    end
                    OP_CYCLE: begin
                        state      <= S_CYCLE;
                        led        <= '0;
                        disp_value <= replicate_digit(4'd0);
                    end
                    default: begin
                        state     <= S_LAUNCH;
                        alu_start <= 1'b1;
                    end
                endcase
            end else begin
                case (state)
                    S_LAUNCH: begin
                        state    <= S_WAIT;
                        wait_cnt <= '0;
                    end
                    S_WAIT: begin
                        // A done arriving on the timeout cycle still counts.
                        if (alu_done) begin
                            state <= S_SHOW;
                            if (alu_err) begin
                                disp_value <= ERR_PATTERN;
                                err        <= 1'b1;
                                led        <= {alu_op, 11'b0, 1'b1};
                            end else begin
                                disp_value <= alu_result;
                                led        <= {alu_op, 11'b0, 1'b0};
                            end
                        end else if (wait_cnt == WAIT_LAST) begin
                            state      <= S_SHOW;
                            disp_value <= ERR_PATTERN;
                            err        <= 1'b1;
                            led        <= {alu_op, 11'b0, 1'b1};
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    S_CYCLE: begin
                        if (tick) begin
                            digit      <= digit_next;
                            disp_value <= replicate_digit(digit_next);
                            led        <= led + 16'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed scenarios plus random
// traffic, checked every cycle against a mode/elapsed-time model.
module tb_alu_op_sequencer;

    localparam int TICK_DIV    = 4;
    localparam int ALU_TIMEOUT = 64;

    localparam int M_IDLE  = 0;
    localparam int M_BUSY  = 1;
    localparam int M_SHOW  = 2;
    localparam int M_LAMP  = 3;
    localparam int M_CYCLE = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] switches;
    logic        go;
    logic        alu_start;
    logic [3:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        alu_err;
    logic [15:0] disp_value;
    logic [15:0] led;
    logic        lamp_test;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_starts = 0;
    bit chk_en   = 1'b0;

    // Model state: what mode we are in and how many edges since entering it.
    int          m_mode;
    int          m_since;
    logic [3:0]  m_op;
    logic [7:0]  m_a;
    logic [7:0]  m_b;
    logic [15:0] m_disp;
    logic [15:0] m_led;
    logic        m_err;
    logic        m_lamp;
    logic        m_start;

    alu_op_sequencer #(
        .TICK_DIV    (TICK_DIV),
        .ALU_TIMEOUT (ALU_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .switches   (switches),
        .go         (go),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .alu_err    (alu_err),
        .disp_value (disp_value),
        .led        (led),
        .lamp_test  (lamp_test),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_finish(input logic e, input logic [15:0] r);
        m_mode = M_SHOW;
        m_err  = e;
        m_disp = e ? 16'hEEEE : r;
        m_led  = {m_op, 11'b0, e};
    endtask

    // Advance the model by one clock edge using the inputs the DUT just sampled.
    task automatic model_edge();
        logic [31:0] k;
        m_start = 1'b0;
        if (reset) begin
            m_mode = M_IDLE; m_since = 0;
            m_op = '0; m_a = '0; m_b = '0;
            m_disp = '0; m_led = '0; m_err = 1'b0; m_lamp = 1'b0;
        end else if (go && m_mode != M_BUSY) begin
            m_op = switches[19:16];
            m_a  = switches[15:8];
            m_b  = switches[7:0];
            m_err = 1'b0; m_lamp = 1'b0; m_since = 0;
            if (m_op == 4'd0) begin
                m_mode = M_SHOW; m_disp = {m_a, m_b}; m_led = 16'h0000;
            end else if (m_op == 4'd1) begin
                m_mode = M_LAMP; m_lamp = 1'b1; m_led = 16'hFFFF; m_disp = 16'h8888;
            end else if (m_op == 4'd2) begin
                m_mode = M_CYCLE; m_disp = 16'h0000; m_led = 16'h0000;
            end else begin
                m_mode = M_BUSY; m_start = 1'b1;
            end
        end else if (m_mode == M_BUSY) begin
            m_since++;
            // since==1 is the launch edge; WAIT edges are since 2..TIMEOUT+1
            if (m_since >= 2 && alu_done)
                model_finish(alu_err, alu_result);
            else if (m_since == ALU_TIMEOUT + 1)
                model_finish(1'b1, 16'h0000);
        end else if (m_mode == M_CYCLE) begin
            m_since++;
            k = m_since / TICK_DIV;
            m_disp = {4{k[3:0]}};
            m_led  = k[15:0];
        end
    endtask

    // One clock: drive inputs, let the edge happen, update the model.
    task automatic step(input logic g, input logic [23:0] sw, input logic d,
                        input logic e, input logic [15:0] r);
        go = g; switches = sw; alu_done = d; alu_err = e; alu_result = r;
        @(posedge clk);
        model_edge();
        #1;
        go = 1'b0; alu_done = 1'b0; alu_err = 1'b0;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, switches, 1'b0, 1'b0, 16'h0);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (alu_start) n_starts++;
        if (chk_en) begin
            check("alu_start", alu_start, m_start);
            check("alu_op", alu_op, m_op);
            check("alu_a", alu_a, m_a);
            check("alu_b", alu_b, m_b);
            check("busy", busy, m_mode == M_BUSY);
            check("err", err, m_err);
            check("lamp_test", lamp_test, m_lamp);
            if (m_mode != M_BUSY) begin
                check("disp_value", disp_value, m_disp);
                check("led", led, m_led);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int starts0;
        int cnt;
        int pct;
        reset = 1'b1; go = 1'b0; switches = '0;
        alu_done = 1'b0; alu_err = 1'b0; alu_result = '0;
        idle_steps(2);
        chk_en = 1'b1;
        reset = 1'b0;
        idle_steps(1);
        check("reset_disp", disp_value, 16'h0000);
        check("reset_busy", busy, 1'b0);

        // Add: done three cycles after the start strobe.
        starts0 = n_starts;
        step(1'b1, 24'h03_1205, 1'b0, 1'b0, 16'h0);
        check("add_start", alu_start, 1'b1);
        idle_steps(3);
        step(1'b0, switches, 1'b1, 1'b0, 16'h0017);
        check("add_disp", disp_value, 16'h0017);
        check("add_led", led, 16'h3000);
        check("add_busy", busy, 1'b0);
        check("model_add_disp", m_disp, 16'h0017);
        check("model_add_led", m_led, 16'h3000);
        check("add_start_count", 16'(n_starts - starts0), 16'd1);

        // Divide by zero reported by the ALU.
        step(1'b1, 24'h06_0900, 1'b0, 1'b0, 16'h0);
        idle_steps(3);
        step(1'b0, switches, 1'b1, 1'b1, 16'h1234);
        check("div0_disp", disp_value, 16'hEEEE);
        check("div0_err", err, 1'b1);
        check("div0_led", led, 16'h6001);
        check("model_div0_led", m_led, 16'h6001);
        step(1'b1, 24'h00_1234, 1'b0, 1'b0, 16'h0);
        check("div0_clear_err", err, 1'b0);
        check("div0_pass_disp", disp_value, 16'h1234);

        // Timeout with ignored GOs during WAIT.
        starts0 = n_starts;
        step(1'b1, 24'h0A_5555, 1'b0, 1'b0, 16'h0);
        cnt = 0;
        while (busy && cnt < 200) begin
            cnt++;
            step((cnt % 7) == 0, 24'h00_ABCD, 1'b0, 1'b0, 16'h0);
        end
        check("timeout_busy_cycles", 16'(cnt), 16'(ALU_TIMEOUT + 1));
        check("timeout_disp", disp_value, 16'hEEEE);
        check("timeout_err", err, 1'b1);
        check("timeout_start_count", 16'(n_starts - starts0), 16'd1);

        // Reset during WAIT abandons the operation.
        step(1'b1, 24'h06_3344, 1'b0, 1'b0, 16'h0);
        idle_steps(5);
        starts0 = n_starts;
        reset = 1'b1;
        idle_steps(1);
        reset = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_op", alu_op, 4'd0);
        check("rst_disp", disp_value, 16'h0000);
        step(1'b0, switches, 1'b1, 1'b0, 16'h5A5A);
        idle_steps(4);
        check("rst_no_start", 16'(n_starts - starts0), 16'd0);
        check("rst_disp_after", disp_value, 16'h0000);

        // Cycle mode with switches wiggling underneath.
        starts0 = n_starts;
        step(1'b1, 24'h02_0000, 1'b0, 1'b0, 16'h0);
        for (int j = 1; j <= 64; j++) begin
            step(1'b0, {8'h02, 16'($urandom)}, 1'b0, 1'b0, 16'h0);
            if (j == 4) check("cycle_1111", disp_value, 16'h1111);
            if (j == 60) check("cycle_FFFF", disp_value, 16'hFFFF);
            if (j == 64) begin
                check("cycle_wrap", disp_value, 16'h0000);
                check("cycle_led", led, 16'h0010);
            end
        end
        step(1'b1, 24'h00_ABCD, 1'b0, 1'b0, 16'h0);
        check("cycle_exit", disp_value, 16'hABCD);

        // Lamp test, then pass-through.
        step(1'b1, 24'h01_0000, 1'b0, 1'b0, 16'h0);
        check("lamp_on", lamp_test, 1'b1);
        check("lamp_led", led, 16'hFFFF);
        check("lamp_disp", disp_value, 16'h8888);
        idle_steps(3);
        step(1'b1, 24'h00_BEEF, 1'b0, 1'b0, 16'h0);
        check("lamp_off", lamp_test, 1'b0);
        check("pass_disp", disp_value, 16'hBEEF);
        check("no_start_lamp_cycle", 16'(n_starts - starts0), 16'd0);

        // Random traffic in bursts with different ALU response rates.
        for (int b = 0; b < 20; b++) begin
            case ($urandom_range(0, 2))
                0: pct = 0;
                1: pct = 4;
                default: pct = 40;
            endcase
            for (int i = 0; i < 200; i++) begin
                logic [23:0] sw;
                sw = 24'($urandom);
                if ($urandom_range(0, 1) == 0) sw[19:16] = 4'($urandom_range(0, 2));
                reset = ($urandom_range(0, 499) == 0);
                step(($urandom_range(0, 7) == 0), sw,
                     ($urandom_range(0, 99) < pct), ($urandom_range(0, 3) == 0),
                     16'($urandom));
                reset = 1'b0;
            end
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Command sequencer between the board switches/GO button and the ALU datapath.
- On each GO pulse it latches the opcode and operands from the switches.
- It either drives a local display mode (pass-through, lamp test, digit cycling) or launches one ALU operation with a start/done handshake.
- It captures the ALU result, with timeout and error handling, and drives the 7-segment value bus and LEDs.

Parameters:
TICK_DIV, 100000000, clk cycles per cycle-mode step (1 s at 100 MHz); sims use 4
ALU_TIMEOUT, 64, max cycles in WAIT before error

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
switches  in  24  [19:16] opcode, [15:8] operand A, [7:0] operand B; [23:20] ignored
go  in  1  single-cycle, already-debounced command pulse
alu_start  out  1  one-cycle launch strobe
alu_op  out  4  latched opcode
alu_a  out  8  latched operand A
alu_b  out  8  latched operand B
alu_done  in  1  result-valid pulse from ALU
alu_result  in  16  ALU result
alu_err  in  1  ALU error (e.g. divide by zero), qualified by alu_done
disp_value  out  16  four hex digits to display driver
led  out  16  LED bank
lamp_test  out  1  forces all segments on
busy  out  1  high in LAUNCH/WAIT
err  out  1  sticky error flag for the current command

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high.
- Reset values: state IDLE, all outputs 0, latched opcode/operands 0, counters 0. Reset in any state, including mid-WAIT, abandons the operation; alu_start is low the cycle after reset.
- States: IDLE, LAUNCH, WAIT, SHOW, LAMP, CYCLE.
- Accepting GO:
  - GO is accepted in IDLE, SHOW, LAMP and CYCLE; GO in LAUNCH or WAIT is ignored.
  - On accept, the block latches op=switches[19:16], a=switches[15:8], b=switches[7:0] and clears err.
  - Next state depends on op:
    - op 0: SHOW, disp_value={a,b}.
    - op 1: LAMP.
    - op 2: CYCLE.
    - op 3..15: LAUNCH.
- LAUNCH:
  - Exactly one cycle, with alu_start=1.
  - alu_op/alu_a/alu_b are stable from LAUNCH until the next accepted GO.
  - Latency: GO sampled at edge N gives alu_start high during cycle N+1.
- WAIT:
  - alu_done is sampled only in WAIT; done in the LAUNCH cycle is ignored.
  - On alu_done: if alu_err=0, disp_value<=alu_result; if alu_err=1, disp_value<=16'hEEEE and err<=1. Go to SHOW. disp_value updates one cycle after done is seen.
  - Wait counter starts at 0 on entry. If it reaches ALU_TIMEOUT with no done: err<=1, disp_value<=16'hEEEE, go to SHOW.
  - alu_done on the same cycle as the timeout: done wins.
- SHOW: holds disp_value; led={op,11'b0,err}.
- LAMP: lamp_test=1, led=16'hFFFF, disp_value=16'h8888. Leaving LAMP clears lamp_test the next cycle.
- CYCLE:
  - Prescaler cleared on entry; tick every TICK_DIV cycles.
  - On tick: digit<=digit+1 (wraps F->0) and led<=led+1 (wraps FFFF->0).
  - disp_value={4{digit}}; digit and led start at 0 on entry.
  - Switches are ignored while in CYCLE.
- busy is combinational from state (LAUNCH or WAIT). All other outputs are registered.
- Switch changes without GO have no effect in any state.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode constants OP_PASS=0, OP_LAMP=1, OP_CYCLE=2, OP_ADD=3 ... OP_XNOR=15;
  - state encoding constants;
  - ERR_PATTERN=16'hEEEE and LAMP_PATTERN=16'h8888.
- Sub-module tick_prescaler: parameter TICK_DIV; ports clk, reset, clear, en, tick; one-cycle tick pulse.
- Target size: roughly 200 lines of RTL.

Test Plan:
- Reset mid-operation: op 6 launched, reset asserted during WAIT -> next cycle state IDLE, all outputs 0, no further alu_start.
- Add: switches=24'h03_1205, GO -> alu_start high exactly 1 cycle, alu_op=3, alu_a=8'h12, alu_b=8'h05; model returns done+16'h0017 three cycles later -> disp_value=16'h0017 next cycle, busy low, led=16'h3000.
- Divide by zero: switches op 6, b=0; model returns done with alu_err=1 -> disp_value=16'hEEEE, err=1, led=16'h6001; next GO clears err.
- Timeout: ALU model never asserts done -> SHOW after exactly ALU_TIMEOUT WAIT cycles, disp_value=16'hEEEE, err=1. GOs pulsed during WAIT are ignored, with no second alu_start.
- Cycle mode, TICK_DIV=4: op 2, GO -> disp_value steps 0000, 1111, ..., FFFF, 0000 every 4 cycles, led increments in step. Changing switches[15:0] has no effect; GO with op 0 exits to SHOW with {a,b}.
- Lamp/pass-through: op 1 -> lamp_test=1, led=FFFF, disp_value=8888. Then op 0 with switches[15:0]=16'hBEEF, GO -> lamp_test=0, disp_value=16'hBEEF, no alu_start ever issued.
